// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide unit with architectural HI/LO registers.
// Define MULDIV_FAST_MUL_EN to compute MULT/MULTU in a single cycle with one multiplier.
// state | meaning
// IDLE  | waiting for start; MTHI/MTLO write here
// RUN   | one product/quotient bit per edge
// FIX   | sign correction and HI/LO write-back
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             cancel,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [WIDTH-1:0]   ONE_W  = WIDTH'(1);
    localparam logic [2*WIDTH-1:0] ONE_2W = (2*WIDTH)'(1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH:0]       rem_q, rem_d;
    logic [WIDTH-1:0]     opb_q, opb_d;
    logic                 is_mul_q, is_mul_d;
    logic                 sign_a_q, sign_a_d;
    logic                 sign_b_q, sign_b_d;
    logic                 div_zero_q, div_zero_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 done_q, done_d;

    logic                 signed_op, mul_op, a_neg, b_neg;
    logic [WIDTH-1:0]     a_mag, b_mag;
    logic [WIDTH:0]       mul_sum;
    logic [WIDTH+1:0]     div_shift, div_diff;
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quot_fix, rem_fix;

    assign signed_op = ~op[0];
    assign mul_op    = ~op[1];
    assign a_neg     = signed_op & a[WIDTH-1];
    assign b_neg     = signed_op & b[WIDTH-1];
    assign a_mag     = a_neg ? (~a + ONE_W) : a;
    assign b_mag     = b_neg ? (~b + ONE_W) : b;

    assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opb_q};
    // The partial remainder never exceeds the divisor, so its top bit only
    // carries the borrow of the trial subtraction.
    assign div_shift = {rem_q, acc_q[WIDTH-1]};
    assign div_diff  = div_shift - {2'b00, opb_q};

    assign prod_fix  = (sign_a_q ^ sign_b_q) ? (~acc_q + ONE_2W) : acc_q;
    assign quot_fix  = div_zero_q ? '1 :
                       (sign_a_q ^ sign_b_q) ? (~acc_q[WIDTH-1:0] + ONE_W) : acc_q[WIDTH-1:0];
    // Negating |a| restores the original dividend on a divide by zero.
    assign rem_fix   = sign_a_q ? (~rem_q[WIDTH-1:0] + ONE_W) : rem_q[WIDTH-1:0];

`ifdef MULDIV_FAST_MUL_EN
    logic [2*WIDTH-1:0] fast_a, fast_b, fast_prod;
    assign fast_a    = {{WIDTH{a_neg}}, a};
    assign fast_b    = {{WIDTH{b_neg}}, b};
    assign fast_prod = fast_a * fast_b;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        rem_d      = rem_q;
        opb_d      = opb_q;
        is_mul_d   = is_mul_q;
        sign_a_d   = sign_a_q;
        sign_b_d   = sign_b_q;
        div_zero_d = div_zero_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        done_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start && !cancel) begin
                    if (!op[2]) begin
                        is_mul_d   = mul_op;
                        sign_a_d   = a_neg;
                        sign_b_d   = b_neg;
                        div_zero_d = (b == '0);
                        rem_d      = '0;
                        cnt_d      = CW'(WIDTH);
                        state_d    = S_RUN;
                        if (mul_op) begin
                            acc_d = {{WIDTH{1'b0}}, b_mag};
                            opb_d = a_mag;
                        end else begin
                            acc_d = {{WIDTH{1'b0}}, a_mag};
                            opb_d = b_mag;
                        end
`ifdef MULDIV_FAST_MUL_EN
                        if (mul_op) begin
                            hi_d    = fast_prod[2*WIDTH-1:WIDTH];
                            lo_d    = fast_prod[WIDTH-1:0];
                            done_d  = 1'b1;
                            cnt_d   = '0;
                            state_d = S_IDLE;
                        end
`endif
                    end else if (op == 3'b100) begin
                        hi_d = a;
                    end else if (op == 3'b101) begin
                        lo_d = a;
                    end
                end
            end
            S_RUN: begin
                if (cancel) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    if (is_mul_q) begin
                        acc_d = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]}
                                         : {1'b0, acc_q[2*WIDTH-1:1]};
                    end else if (!div_diff[WIDTH+1]) begin
                        rem_d = div_diff[WIDTH:0];
                        acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_d = div_shift[WIDTH:0];
                        acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], 1'b0};
                    end
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) state_d = S_FIX;
                end
            end
            S_FIX: begin
                state_d = S_IDLE;
                if (!cancel) begin
                    done_d = 1'b1;
                    if (is_mul_q) begin
                        hi_d = prod_fix[2*WIDTH-1:WIDTH];
                        lo_d = prod_fix[WIDTH-1:0];
                    end else begin
                        hi_d = rem_fix;
                        lo_d = quot_fix;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            rem_q      <= '0;
            opb_q      <= '0;
            is_mul_q   <= 1'b0;
            sign_a_q   <= 1'b0;
            sign_b_q   <= 1'b0;
            div_zero_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            rem_q      <= rem_d;
            opb_q      <= opb_d;
            is_mul_q   <= is_mul_d;
            sign_a_q   <= sign_a_d;
            sign_b_q   <= sign_b_d;
            div_zero_q <= div_zero_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            done_q     <= done_d;
        end
    end

    assign busy = (state_q != S_IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: arithmetic results, latency, handshake, cancel and reset.
module tb_muldiv_unit;
    localparam int W = 32;
    localparam int DIV_EDGES = W + 1;
`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_EDGES = 0;
`else
    localparam int MUL_EDGES = W + 1;
`endif

    logic         clk = 1'b0;
    logic         reset, start, cancel;
    logic [2:0]   op;
    logic [W-1:0] a, b;
    logic         busy, done;
    logic [W-1:0] hi, lo;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .cancel(cancel), .op(op),
        .a(a), .b(b), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    task automatic check_val(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Issues one op at a negedge and waits (bounded) for done.
    task automatic run_op(input string tag, input logic [2:0] o, input logic [W-1:0] x,
                          input logic [W-1:0] y, input logic [W-1:0] exp_hi,
                          input logic [W-1:0] exp_lo, input int exp_edges);
        int edges, busy_cnt, moved;
        logic [W-1:0] hi0, lo0;
        hi0 = hi;
        lo0 = lo;
        op = o; a = x; b = y; start = 1'b1;
        step();
        start = 1'b0;
        edges = 0; busy_cnt = 0; moved = 0;
        while (!done && edges < 100) begin
            if (busy) begin
                busy_cnt++;
                if (hi !== hi0 || lo !== lo0) moved++;
            end
            step();
            edges++;
        end
        check_val({tag, "_done_edge"}, edges, exp_edges);
        check_val({tag, "_busy_cycles"}, busy_cnt, exp_edges);
        check_val({tag, "_hilo_hold"}, moved, 0);
        check_val({tag, "_hi"}, hi, exp_hi);
        check_val({tag, "_lo"}, lo, exp_lo);
        step();
        check_val({tag, "_done_pulse"}, {31'b0, done}, 0);
    endtask

    task automatic move_op(input logic [2:0] o, input logic [W-1:0] x);
        op = o; a = x; start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        int done_seen;
        reset = 1'b0; start = 1'b0; cancel = 1'b0; op = 3'b000; a = '0; b = '0;
        repeat (3) @(negedge clk);
        check_val("rst_hi", hi, 0);
        check_val("rst_lo", lo, 0);
        check_val("rst_busy", {31'b0, busy}, 0);
        check_val("rst_done", {31'b0, done}, 0);
        reset = 1'b1;
        step();

        // MTHI then MTLO on consecutive cycles
        op = 3'b100; a = 32'h12345678; start = 1'b1;
        step();
        check_val("mthi_hi", hi, 32'h12345678);
        check_val("mthi_busy", {30'b0, busy, done}, 0);
        op = 3'b101; a = 32'h9ABCDEF0;
        step();
        start = 1'b0;
        check_val("mtlo_lo", lo, 32'h9ABCDEF0);
        check_val("mtlo_hi", hi, 32'h12345678);
        check_val("mtlo_busy", {30'b0, busy, done}, 0);

        // cancel beats start in idle; ops 110/111 are ignored
        op = 3'b100; a = 32'hDEADBEEF; start = 1'b1; cancel = 1'b1;
        step();
        start = 1'b0; cancel = 1'b0;
        check_val("cancel_start_hi", hi, 32'h12345678);
        op = 3'b110; a = 32'h0BADF00D; b = 32'h3; start = 1'b1;
        step();
        op = 3'b111;
        step();
        start = 1'b0;
        check_val("nop_hi", hi, 32'h12345678);
        check_val("nop_lo", lo, 32'h9ABCDEF0);
        check_val("nop_busy", {30'b0, busy, done}, 0);

        run_op("multu_max", 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, MUL_EDGES);
        run_op("mult_neg", 3'b000, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, MUL_EDGES);
        run_op("mult_minmin", 3'b000, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, MUL_EDGES);
        run_op("div_neg", 3'b010, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, DIV_EDGES);
        run_op("divu", 3'b011, 32'd100, 32'd7, 32'd2, 32'd14, DIV_EDGES);
        run_op("div_zero", 3'b010, 32'h00001234, 32'h0, 32'h00001234, 32'hFFFFFFFF, DIV_EDGES);
        run_op("div_zero_neg", 3'b010, 32'hFFFFFFF9, 32'h0, 32'hFFFFFFF9, 32'hFFFFFFFF, DIV_EDGES);
        run_op("div_ovf", 3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, DIV_EDGES);

        // second start ignored, cancel squashes without done
        move_op(3'b100, 32'hAAAA0000);
        move_op(3'b101, 32'h0000BBBB);
        op = 3'b011; a = 32'd1000; b = 32'd3; start = 1'b1;
        step();
        start = 1'b0;
        repeat (4) step();
        op = 3'b100; a = 32'h55555555; start = 1'b1;
        step();
        start = 1'b0;
        check_val("busy_restart_hi", hi, 32'hAAAA0000);
        repeat (3) step();
        check_val("busy_before_cancel", {31'b0, busy}, 1);
        cancel = 1'b1;
        step();
        cancel = 1'b0;
        check_val("cancel_busy", {31'b0, busy}, 0);
        check_val("cancel_done", {31'b0, done}, 0);
        check_val("cancel_hi", hi, 32'hAAAA0000);
        check_val("cancel_lo", lo, 32'h0000BBBB);
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) done_seen++;
            step();
        end
        check_val("cancel_no_done", done_seen, 0);

        // reset mid-operation clears everything at once
        op = 3'b011; a = 32'd1000; b = 32'd3; start = 1'b1;
        step();
        start = 1'b0;
        repeat (9) step();
        check_val("busy_before_reset", {31'b0, busy}, 1);
        reset = 1'b0;
        #1;
        check_val("rstmid_hi", hi, 0);
        check_val("rstmid_lo", lo, 0);
        check_val("rstmid_busy", {31'b0, busy}, 0);
        @(negedge clk);
        reset = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (done || busy) done_seen++;
            step();
        end
        check_val("rstmid_quiet", done_seen, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
